// File: rtl/mem_pkg.sv
// Shared op codes, FSM state encoding and request classification helpers
// for the RAM initiator.
package mem_pkg;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Halfword ops need an even address, word ops a multiple of four.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lsb);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lsb[0];
      OP_LW, OP_SW:         return |lsb;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// MIPS load result shaping: picks byte/half/word from the captured RAM word
// and applies sign or zero extension according to the op code.
module load_extend
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] word,
  output logic [31:0] result
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    result = word;
    case (op)
      OP_LB:   result = {{24{word[7]}}, word[7:0]};
      OP_LBU:  result = {24'h0, word[7:0]};
      OP_LH:   result = {{16{word[15]}}, word[15:0]};
      OP_LHU:  result = {16'h0, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a byte-addressed, word-wide RAM; SB/SH run as
// read-modify-write. Define MEM_ALIGN_CHECK_EN to reject unaligned LH/LHU/SH/LW/SW.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic [ADDR_W:0]   end_addr;
  logic              out_of_range;
  logic              misaligned;
  logic              reject;
  logic [31:0]       load_result;

  assign accept = (state_q == ST_IDLE) && req_valid;

  // One extra bit so that addr+3 wrapping past the top of the bus is caught.
  assign end_addr     = {1'b0, req_addr} + (ADDR_W + 1)'(3);
  assign out_of_range = end_addr >= (ADDR_W + 1)'(MEM_BYTES);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(req_op, req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign reject = !(is_load(req_op) || is_store(req_op)) || out_of_range || misaligned;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (reject)              state_d = ST_RESP;
          else if (req_op == OP_SW) state_d = ST_WR;
          else                     state_d = ST_RD;
        end
      end
      ST_RD:   state_d = is_store(op_q) ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= reject;
      end
      if (state_q == ST_RD) rdata_q <= mem_rdata;
    end
  end

  load_extend u_load_extend (
    .op     (op_q),
    .word   (rdata_q),
    .result (load_result)
  );

  // Moore outputs: strobes exist only in RD/WR, so a reset drops them at once.
  assign req_ready = (state_q == ST_IDLE);
  assign mem_re    = (state_q == ST_RD);
  assign mem_we    = (state_q == ST_WR);
  assign mem_addr  = (mem_re || mem_we) ? addr_q : '0;

  always_comb begin
    mem_wdata = '0;
    if (mem_we) begin
      case (op_q)
        OP_SB:   mem_wdata = {rdata_q[31:8], wdata_q[7:0]};
        OP_SH:   mem_wdata = {rdata_q[31:16], wdata_q[15:0]};
        default: mem_wdata = wdata_q;
      endcase
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && is_load(op_q)) ? load_result : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte RAM model, table-driven
// requests with a response scoreboard, plus a reset-during-RMW sequence.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned ADDR_W    = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Little-endian byte RAM, combinational read, write on the clock while mem_we.
  logic [7:0] ram [MEM_BYTES];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    int i;
    if (a > 32'(MEM_BYTES - 4)) return 32'h0;
    i = int'(a);
    return {ram[i+3], ram[i+2], ram[i+1], ram[i]};
  endfunction

  assign mem_rdata = mem_re ? rd_word(mem_addr) : 32'h0;

  always @(posedge clk) begin
    if (mem_we && mem_addr <= 32'(MEM_BYTES - 4)) begin
      for (int k = 0; k < 4; k++) ram[int'(mem_addr) + k] <= mem_wdata[8*k +: 8];
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mwd;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mwd;
    int          re;
    int          we;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input logic [31:0] mwd);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err; v.mwd = mwd;
    return v;
  endfunction

  // Drive a request (valid held across busy cycles) and queue its expected response.
  task automatic issue(input vec_t v);
    exp_t e;
    bit   done = 0;
    bit   rmw;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = v.op;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      if (req_ready) begin
        rmw    = (v.op == OP_SB) || (v.op == OP_SH);
        e.addr  = v.addr;
        e.rdata = v.rdata;
        e.err   = v.err;
        e.mwd   = v.mwd;
        e.re    = (v.err || v.op == OP_SW) ? 0 : 1;
        e.we    = (!v.err && (rmw || v.op == OP_SW)) ? 1 : 0;
        e.cyc   = cyc + (v.err ? 1 : (rmw ? 3 : 2));
        sb.push_back(e);
        done = 1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk);
      #1;
      check("ready_low_busy", {31'h0, req_ready}, 32'h0);
    end
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  // Monitor: strobe accounting and in-order response comparison.
  int          re_cnt = 0;
  int          we_cnt = 0;
  logic [31:0] last_wd = '0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      re_cnt = 0;
      we_cnt = 0;
    end else begin
      if (mem_re || mem_we) begin
        check("strobe_exclusive", {31'h0, mem_re & mem_we}, 32'h0);
        if (sb.size() == 0) check("stray_strobe", 32'h1, 32'h0);
        else check("mem_addr", mem_addr, sb[0].addr);
        if (mem_re) re_cnt++;
        if (mem_we) begin
          we_cnt++;
          last_wd = mem_wdata;
        end
      end
      if (resp_valid) begin
        check("resp_strobe_free", {30'h0, mem_re, mem_we}, 32'h0);
        if (sb.size() == 0) check("unexpected_resp", 32'h1, 32'h0);
        else begin
          mon_e = sb.pop_front();
          check("resp_rdata", resp_rdata, mon_e.rdata);
          check("resp_err", {31'h0, resp_err}, {31'h0, mon_e.err});
          check("resp_cycle", cyc, mon_e.cyc);
          check("re_count", 32'(re_cnt), 32'(mon_e.re));
          check("we_count", 32'(we_cnt), 32'(mon_e.we));
          if (mon_e.we != 0) check("mem_wdata", last_wd, mon_e.mwd);
        end
        re_cnt = 0;
        we_cnt = 0;
      end else begin
        check("idle_resp_zero", {resp_err, resp_rdata[30:0]} | {31'h0, resp_rdata[31]}, 32'h0);
      end
    end
  end

  initial begin
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < int'(MEM_BYTES); i++) ram[i] = 8'h00;
    ram[0] = 8'hF0;
    ram[3] = 8'h80;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_re", {31'h0, mem_re}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    vecs.push_back(mk(OP_LB,  32'd0,  32'h0, 32'hFFFF_FFF0, 1'b0, 32'h0));
    vecs.push_back(mk(OP_LBU, 32'd0,  32'h0, 32'h0000_00F0, 1'b0, 32'h0));
    vecs.push_back(mk(OP_LH,  32'd2,  32'h0, 32'hFFFF_8000, 1'b0, 32'h0));
    vecs.push_back(mk(OP_LHU, 32'd2,  32'h0, 32'h0000_8000, 1'b0, 32'h0));
    vecs.push_back(mk(OP_SW,  32'd8,  32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF));
    vecs.push_back(mk(OP_LW,  32'd8,  32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0));
    vecs.push_back(mk(OP_SB,  32'd8,  32'h0000_0011, 32'h0, 1'b0, 32'hDEAD_BE11));
    vecs.push_back(mk(OP_LW,  32'd8,  32'h0, 32'hDEAD_BE11, 1'b0, 32'h0));
    vecs.push_back(mk(OP_SH,  32'd8,  32'h1234_CAFE, 32'h0, 1'b0, 32'hDEAD_CAFE));
    vecs.push_back(mk(OP_LH,  32'd8,  32'h0, 32'hFFFF_CAFE, 1'b0, 32'h0));
    vecs.push_back(mk(OP_LBU, 32'd11, 32'h0, 32'h0000_00DE, 1'b0, 32'h0));
    vecs.push_back(mk(OP_LB,  32'd11, 32'h0, 32'hFFFF_FFDE, 1'b0, 32'h0));
    vecs.push_back(mk(OP_SW,  32'd16, 32'h0102_0304, 32'h0, 1'b0, 32'h0102_0304));
    vecs.push_back(mk(OP_LB,  32'd19, 32'h0, 32'h0000_0001, 1'b0, 32'h0));
    vecs.push_back(mk(OP_LBU, 32'd17, 32'h0, 32'h0000_0003, 1'b0, 32'h0));
    vecs.push_back(mk(OP_LW,  32'd1021, 32'h0, 32'h0, 1'b1, 32'h0));
    vecs.push_back(mk(OP_LW,  32'd1020, 32'h0, 32'h0, 1'b0, 32'h0));
    vecs.push_back(mk(OP_SW,  32'd1021, 32'h5555_5555, 32'h0, 1'b1, 32'h0));
    vecs.push_back(mk(OP_SB,  32'd1023, 32'h0000_0077, 32'h0, 1'b1, 32'h0));
    vecs.push_back(mk(OP_LB,  32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1, 32'h0));
    vecs.push_back(mk(4'b1111, 32'd0, 32'h0, 32'h0, 1'b1, 32'h0));
    vecs.push_back(mk(4'b0110, 32'd0, 32'h0, 32'h0, 1'b1, 32'h0));
`ifdef MEM_ALIGN_CHECK_EN
    vecs.push_back(mk(OP_LW,  32'd2,  32'h0, 32'h0, 1'b1, 32'h0));
    vecs.push_back(mk(OP_LH,  32'd3,  32'h0, 32'h0, 1'b1, 32'h0));
    vecs.push_back(mk(OP_LW,  32'd17, 32'h0, 32'h0, 1'b1, 32'h0));
    vecs.push_back(mk(OP_SH,  32'd1,  32'h0000_BEEF, 32'h0, 1'b1, 32'h0));
    vecs.push_back(mk(OP_LW,  32'd0,  32'h0, 32'h8000_00F0, 1'b0, 32'h0));
`else
    vecs.push_back(mk(OP_LW,  32'd2,  32'h0, 32'h0000_8000, 1'b0, 32'h0));
    vecs.push_back(mk(OP_LH,  32'd3,  32'h0, 32'h0000_0080, 1'b0, 32'h0));
    vecs.push_back(mk(OP_LW,  32'd17, 32'h0, 32'h0001_0203, 1'b0, 32'h0));
    vecs.push_back(mk(OP_SH,  32'd1,  32'h0000_BEEF, 32'h0, 1'b0, 32'h0080_BEEF));
    vecs.push_back(mk(OP_LW,  32'd0,  32'h0, 32'h80BE_EFF0, 1'b0, 32'h0));
`endif

    // Valid stays high between table entries, so these run back to back.
    foreach (vecs[i]) issue(vecs[i]);
    drain();

    // Reset while an SH sits in its RD cycle: no write, no response.
    issue(mk(OP_SH, 32'd8, 32'h0000_7777, 32'h0, 1'b0, 32'h0));
    check("rmw_in_rd", {31'h0, mem_re}, 32'h1);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_mid_re", {31'h0, mem_re}, 32'h0);
    check("rst_mid_we", {31'h0, mem_we}, 32'h0);
    check("rst_mid_resp", {31'h0, resp_valid}, 32'h0);
    check("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    if (sb.size() != 0) sb.delete(sb.size() - 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", {31'h0, req_ready}, 32'h1);
    issue(mk(OP_LW, 32'd8, 32'h0, 32'hDEAD_CAFE, 1'b0, 32'h0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
